d_latch: RTL and testbench

- Level-sensitive, WIDTH-bit transparent D latch bank with asynchronous active-low clear.
- Enable high: Q follows I. Enable low: Q holds the last value.
- Clock-domain side logic provides a registered copy of Q, a change-detect pulse and an optional hold-duration counter, so synchronous consumers can observe latch state safely.
- Used as a storage primitive for level-captured control/status fields.

---
 rtl/d_latch_pkg.sv | 14 +
 rtl/d_latch_cell.sv | 20 ++
 rtl/d_latch.sv | 62 ++++++
 tb/tb_d_latch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d_latch_pkg.sv
// Shared defaults and helpers for the d_latch storage bank.
package d_latch_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned DEFAULT_CNT_W = 8;

  // Increment val by one, saturating at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/d_latch_cell.sv
// Single-bit transparent latch with asynchronous active-low clear.
module d_latch_cell (
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);

  // Level-sensitive storage: clear dominates, transparent while en is high.
  // NOTE: always_latch makes the intended latch explicit so tools flag any
  // accidental one elsewhere; non-blocking keeps it consistent with other state.
  always_latch begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_latch.sv
// WIDTH-bit transparent latch bank with clocked observation logic.
// Optional hold-duration counter enabled by defining D_LATCH_HOLD_CNT_EN;
// without it hold_cnt is tied to zero and no counter flops exist.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] q_sync,
  output logic             q_changed,
  output logic [CNT_W-1:0] hold_cnt
);

  // One latch per bit; all bits share the enable and clear.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    d_latch_cell u_cell (
      .rst_n (rst_n),
      .en    (En),
      .d     (I[i]),
      .q     (Q[i])
    );
  end

  // Register the latch output and flag any change of the registered value.
  // NOTE: only control/observation flops take the async clear; there is no
  // memory here, and every flop must reset so q_changed is 0 after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sync    <= '0;
      q_changed <= 1'b0;
    end else begin
      q_sync    <= Q;
      q_changed <= (Q != q_sync);
    end
  end

`ifdef D_LATCH_HOLD_CNT_EN
  logic [CNT_W-1:0] hold_cnt_q;

  // Count clk cycles spent in hold, saturating; cleared once En is seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (En) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= CNT_W'(sat_inc(32'(hold_cnt_q), CNT_W));
    end
  end

  assign hold_cnt = hold_cnt_q;
`else
  assign hold_cnt = '0;
`endif

endmodule

// File: tb/tb_d_latch.sv
// Directed self-checking bench for d_latch (WIDTH=4, CNT_W=4).
module tb_d_latch;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
`ifdef D_LATCH_HOLD_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             En;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] q_sync;
  logic             q_changed;
  logic [CNT_W-1:0] hold_cnt;

  int checks;
  int errors;

  d_latch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .En        (En),
    .I         (I),
    .Q         (Q),
    .q_sync    (q_sync),
    .q_changed (q_changed),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    En    = 1'b1;
    I     = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Q !== 4'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", Q); end
    checks++;
    if (q_sync !== 4'h0) begin errors++; $display("FAIL reset_q_sync: got %h expected 0", q_sync); end
    checks++;
    if (q_changed !== 1'b0) begin errors++; $display("FAIL reset_q_changed: got %b expected 0", q_changed); end
    checks++;
    if (hold_cnt !== 4'h0) begin errors++; $display("FAIL reset_hold_cnt: got %h expected 0", hold_cnt); end
    @(negedge clk);
    En    = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (Q !== 4'h0) begin errors++; $display("FAIL release_q: got %h expected 0", Q); end
    @(posedge clk);
    #1;
    checks++;
    if (q_sync !== 4'h0) begin errors++; $display("FAIL release_q_sync: got %h expected 0", q_sync); end
    checks++;
    if (q_changed !== 1'b0) begin errors++; $display("FAIL release_q_changed: got %b expected 0", q_changed); end
  endtask

  task automatic test_hold_then_transparent();
    @(negedge clk);
    I = 4'hF;
    #1;
    checks++;
    if (Q !== 4'h0) begin errors++; $display("FAIL hold_ignores_i: got %h expected 0", Q); end
    @(negedge clk);
    En = 1'b1;
    #1;
    checks++;
    if (Q !== 4'hF) begin errors++; $display("FAIL open_q: got %h expected f", Q); end
    checks++;
    if (q_sync !== 4'h0) begin errors++; $display("FAIL open_q_sync_early: got %h expected 0", q_sync); end
    @(posedge clk);
    #1;
    checks++;
    if (q_sync !== 4'hF) begin errors++; $display("FAIL open_q_sync: got %h expected f", q_sync); end
    checks++;
    if (q_changed !== 1'b1) begin errors++; $display("FAIL open_q_changed: got %b expected 1", q_changed); end
    @(posedge clk);
    #1;
    checks++;
    if (q_changed !== 1'b0) begin errors++; $display("FAIL open_pulse_end: got %b expected 0", q_changed); end
  endtask

  task automatic test_hold_keeps();
    logic [WIDTH-1:0] vals [4] = '{4'h0, 4'h5, 4'hA, 4'h0};
    @(negedge clk);
    En = 1'b0;
    #1;
    checks++;
    if (Q !== 4'hF) begin errors++; $display("FAIL hold_close_q: got %h expected f", Q); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      I = vals[k];
      #1;
      checks++;
      if (Q !== 4'hF) begin errors++; $display("FAIL hold_q_%0d: got %h expected f", k, Q); end
    end
    @(posedge clk);
    #1;
    checks++;
    if (q_sync !== 4'hF) begin errors++; $display("FAIL hold_q_sync: got %h expected f", q_sync); end
    checks++;
    if (q_changed !== 1'b0) begin errors++; $display("FAIL hold_q_changed: got %b expected 0", q_changed); end
  endtask

  task automatic test_transparent_follows();
    logic [WIDTH-1:0] vals [4] = '{4'h1, 4'h0, 4'hA, 4'h5};
    @(negedge clk);
    I = 4'h0;
    #1;
    En = 1'b1;
    #1;
    checks++;
    if (Q !== 4'h0) begin errors++; $display("FAIL follow_q_open: got %h expected 0", Q); end
    @(posedge clk);
    #1;
    checks++;
    if (q_sync !== 4'h0) begin errors++; $display("FAIL follow_q_sync0: got %h expected 0", q_sync); end
    checks++;
    if (q_changed !== 1'b1) begin errors++; $display("FAIL follow_q_changed0: got %b expected 1", q_changed); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      I = vals[k];
      #1;
      checks++;
      if (Q !== vals[k]) begin errors++; $display("FAIL follow_q_%0d: got %h expected %h", k, Q, vals[k]); end
    end
    @(posedge clk);
    #1;
    checks++;
    if (q_sync !== 4'h5) begin errors++; $display("FAIL follow_q_sync: got %h expected 5", q_sync); end
    checks++;
    if (q_changed !== 1'b1) begin errors++; $display("FAIL follow_q_changed: got %b expected 1", q_changed); end
  endtask

  task automatic test_bit_independence();
    @(negedge clk);
    I = 4'h3;
    #1;
    checks++;
    if (Q !== 4'h3) begin errors++; $display("FAIL bits_open: got %h expected 3", Q); end
    En = 1'b0;
    #1;
    I = 4'hC;
    #1;
    checks++;
    if (Q !== 4'h3) begin errors++; $display("FAIL bits_hold: got %h expected 3", Q); end
    @(posedge clk);
    #1;
    checks++;
    if (q_sync !== 4'h3) begin errors++; $display("FAIL bits_q_sync: got %h expected 3", q_sync); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals [4] = '{4'h1, 4'h2, 4'h2, 4'h4};
    logic             chg  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      I  = vals[k];
      En = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (q_sync !== vals[k]) begin errors++; $display("FAIL b2b_q_sync_%0d: got %h expected %h", k, q_sync, vals[k]); end
      checks++;
      if (q_changed !== chg[k]) begin errors++; $display("FAIL b2b_q_changed_%0d: got %b expected %b", k, q_changed, chg[k]); end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    I  = 4'hF;
    En = 1'b1;
    #1;
    En = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (q_sync !== 4'hF) begin errors++; $display("FAIL midrst_pre_q_sync: got %h expected f", q_sync); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Q !== 4'h0) begin errors++; $display("FAIL midrst_q: got %h expected 0", Q); end
    checks++;
    if (q_sync !== 4'h0) begin errors++; $display("FAIL midrst_q_sync: got %h expected 0", q_sync); end
    checks++;
    if (q_changed !== 1'b0) begin errors++; $display("FAIL midrst_q_changed: got %b expected 0", q_changed); end
    checks++;
    if (hold_cnt !== 4'h0) begin errors++; $display("FAIL midrst_hold_cnt: got %h expected 0", hold_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (Q !== 4'h0) begin errors++; $display("FAIL midrst_release_q: got %h expected 0", Q); end
    @(posedge clk);
    #1;
    checks++;
    if (q_changed !== 1'b0) begin errors++; $display("FAIL midrst_release_chg: got %b expected 0", q_changed); end
  endtask

  task automatic test_hold_cnt();
    logic [CNT_W-1:0] exp_cnt;
    @(negedge clk);
    En = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (hold_cnt !== 4'h0) begin errors++; $display("FAIL cnt_start: got %h expected 0", hold_cnt); end
    @(negedge clk);
    En = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_cnt = CNT_ON ? ((k > 15) ? 4'hF : 4'(k)) : 4'h0;
      checks++;
      if (hold_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_cycle_%0d: got %h expected %h", k, hold_cnt, exp_cnt); end
    end
    @(negedge clk);
    En = 1'b1;
    #1;
    exp_cnt = CNT_ON ? 4'hF : 4'h0;
    checks++;
    if (hold_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_before_clear: got %h expected %h", hold_cnt, exp_cnt); end
    @(posedge clk);
    #1;
    checks++;
    if (hold_cnt !== 4'h0) begin errors++; $display("FAIL cnt_clear: got %h expected 0", hold_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hold_then_transparent();
    test_hold_keeps();
    test_transparent_follows();
    test_bit_independence();
    test_back_to_back();
    test_mid_reset();
    test_hold_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
